// File: rtl/console_fanout_pkg.sv
// Shared console constants and the UART-path state type for the console fan-out block.
package libstd;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [1:0] {
    U_IDLE,
    U_CR,
    U_BYTE,
    U_DONE
  } console_uart_state_t;

endpackage

// File: rtl/console_fifo.sv
// DEPTH x 8 synchronous FIFO with a combinational head; pointers wrap naturally (DEPTH is a power of two).
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstin,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/console_fanout.sv
// Buffers console bytes and copies each one to the LCD and RS-232 sinks, with optional LF->CRLF
// expansion on the RS-232 path and a per-sink stall timeout so a dead sink cannot wedge the core.
module console_fanout
  import libstd::*;
#(
  parameter int DEPTH         = 16,
  parameter int LF_TO_CRLF    = 1,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rstin,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [7:0]             in_bits,
  output logic                   lcd_val,
  input  logic                   lcd_rdy,
  output logic [7:0]             lcd_bits,
  output logic                   uart_val,
  input  logic                   uart_rdy,
  output logic [7:0]             uart_bits,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(STALL_TIMEOUT) + 1;
  localparam bit TO_EN = (STALL_TIMEOUT != 0);
  localparam logic [TW-1:0] TO_LAST = TW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);

  logic [7:0]          head;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_next;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                in_rdy_q;
  logic                lcd_done;
  console_uart_state_t ustate;
  logic [TW-1:0]       lcd_stall;
  logic [TW-1:0]       uart_stall;
  logic                lcd_acc, lcd_to, lcd_fin;
  logic                uart_acc, uart_to, uart_fin;
  logic [16:0]         drop_sum;

  console_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstin (rstin),
    .push  (push),
    .pop   (pop),
    .wdata (in_bits),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign in_rdy    = in_rdy_q;
  assign push      = in_val && in_rdy_q && !full;
  assign level     = count;

  assign lcd_val   = !empty && !lcd_done;
  assign lcd_bits  = head;
  assign uart_val  = (ustate == U_CR) || (ustate == U_BYTE);
  assign uart_bits = (ustate == U_CR) ? CHAR_CR : head;

  assign lcd_acc  = lcd_val && lcd_rdy;
  assign lcd_to   = TO_EN && lcd_val && !lcd_rdy && (lcd_stall == TO_LAST);
  assign lcd_fin  = lcd_done || lcd_acc || lcd_to;
  assign uart_acc = uart_val && uart_rdy;
  assign uart_to  = TO_EN && uart_val && !uart_rdy && (uart_stall == TO_LAST);
  assign uart_fin = (ustate == U_DONE) || ((ustate == U_BYTE) && uart_acc) || uart_to;

  // The head leaves only once both sinks have taken (or given up on) their copy.
  assign pop      = !empty && lcd_fin && uart_fin;
  assign drop_sum = {1'b0, drop_cnt} + 17'(lcd_to) + 17'(uart_to);

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      in_rdy_q   <= 1'b0;
      lcd_done   <= 1'b0;
      lcd_stall  <= '0;
      uart_stall <= '0;
      drop_cnt   <= '0;
    end else begin
      in_rdy_q <= (count_next != CW'(DEPTH));

      if (pop)                    lcd_done <= 1'b0;
      else if (lcd_acc || lcd_to) lcd_done <= 1'b1;

      if (!lcd_val || lcd_acc || pop) lcd_stall <= '0;
      else                            lcd_stall <= lcd_stall + TW'(1);

      if (!uart_val || uart_acc || pop) uart_stall <= '0;
      else                              uart_stall <= uart_stall + TW'(1);

      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // A timeout while the CR is pending abandons the whole head, LF included.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      ustate <= U_IDLE;
    end else begin
      case (ustate)
        U_IDLE: if (!empty) ustate <= ((LF_TO_CRLF != 0) && (head == CHAR_LF)) ? U_CR : U_BYTE;
        U_CR: begin
          if (uart_to)       ustate <= pop ? U_IDLE : U_DONE;
          else if (uart_acc) ustate <= U_BYTE;
        end
        U_BYTE: if (uart_acc || uart_to) ustate <= pop ? U_IDLE : U_DONE;
        U_DONE: if (pop) ustate <= U_IDLE;
        default: ustate <= U_IDLE;
      endcase
    end
  end

endmodule

// File: doc/console_fanout.md
Name: console_fanout

Overview:
- Sits directly downstream of the core's console output port (console_out_val/rdy/bits).
- Buffers console bytes in a FIFO and delivers each byte to two sinks: the LCD controller and the RS-232 transmit controller.
- Optionally expands LF into CR LF on the RS-232 path only.
- A per-sink stall timeout stops a dead or absent sink from back-pressuring the core forever.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two and at least 2.
- LF_TO_CRLF, 1, when 1 the RS-232 path emits 8'h0D before every 8'h0A.
- STALL_TIMEOUT, 4096, cycles a sink may hold val high without rdy before its copy of the head byte is dropped; 0 disables the timeout.

Ports:
- clk  in  1  single clock for the whole block.
- rstin  in  1  asynchronous, active-low reset.
- in_val  in  1  console byte valid, from the core.
- in_rdy  out  1  block can accept a byte.
- in_bits  in  8  console byte.
- lcd_val  out  1  byte valid to the LCD controller.
- lcd_rdy  in  1  LCD controller accepts the byte.
- lcd_bits  out  8  byte to the LCD controller.
- uart_val  out  1  byte valid to the RS-232 transmit controller.
- uart_rdy  in  1  RS-232 transmit controller accepts the byte.
- uart_bits  out  8  byte to the RS-232 transmit controller.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  16  number of sink-bytes dropped by timeout; saturates at 16'hFFFF.

Behaviour:
- Reset (rstin low, asynchronous):
  - Clears write/read pointers, count, sink-done flags, UART state, timeout counters and drop_cnt.
  - Outputs during and after reset: in_rdy=0 while rstin is low, then 1. lcd_val=0, uart_val=0, level=0, drop_cnt=0.
  - Bits outputs are don't-care while their val is low.
- Handshakes:
  - A transfer occurs on a cycle with val&&rdy.
  - Each val stays high and its bits stay stable until accepted or timed out.
- Input side:
  - in_rdy = (count != DEPTH), driven from a register; there is no bypass when full.
  - A byte pushed at edge N appears on the sink outputs from cycle N+1 (1-cycle latency when empty).
- Head delivery:
  - Head is the FIFO entry at the read pointer, read combinationally.
  - Flags lcd_done and uart_done track completion per sink.
  - lcd_val = (count != 0) && !lcd_done.
  - The head pops when both sinks are done, or become done in the current cycle. On pop, both flags clear.
- Push and pop together:
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
- UART path FSM (states U_IDLE, U_CR, U_BYTE, U_DONE):
  - U_IDLE is the state while the FIFO is empty.
  - When the FIFO is non-empty and the head is 8'h0A with LF_TO_CRLF=1, go to U_CR. Otherwise go to U_BYTE.
  - U_CR: uart_bits=8'h0D; on accept go to U_BYTE.
  - U_BYTE: uart_bits=head; on accept set uart_done and go to U_DONE.
  - U_DONE: wait for pop, then re-evaluate the new head the next cycle.
  - Each head therefore costs at least one extra cycle on the UART path (U_IDLE/U_DONE re-entry). This is acceptable for console rates.
- Timeout (STALL_TIMEOUT != 0), per sink:
  - The counter increments each cycle the sink's val=1 and rdy=0.
  - It clears on accept, on pop, and when val=0.
  - When the counter reaches STALL_TIMEOUT-1 and rdy=0, the sink is marked done and drop_cnt increments by 1.
  - A UART timeout in U_CR skips the rest of that head, including the LF.
  - Simultaneous LCD and UART timeouts add 2 to drop_cnt, saturating.
  - An accept on the same cycle the threshold is reached counts as an accept, not a drop.
- Width rules:
  - count is $clog2(DEPTH)+1 bits.
  - Timeout counters are $clog2(STALL_TIMEOUT)+1 bits.
  - drop_cnt saturates and never wraps.

Decomposition:
- libstd holds:
  - constants CHAR_LF=8'h0A and CHAR_CR=8'h0D;
  - typedef enum console_uart_state_t {U_IDLE,U_CR,U_BYTE,U_DONE}.
- One sub-module, console_fifo: parameterised DEPTH x 8 synchronous FIFO with push, pop, head, count, full and empty, sharing clk and rstin.
- The sink tracking, UART FSM and timeout logic live in console_fanout itself.

Test Plan:
- Reset then idle, both rdy=1 → in_rdy=1, lcd_val=0, uart_val=0, level=0, drop_cnt=0.
- Push 'A','B','C' back-to-back with both rdy=1 → each sink receives 41,42,43 in order; level returns to 0; drop_cnt=0.
- Push 8'h0A with LF_TO_CRLF=1 → uart sees 0D then 0A; lcd sees only 0A; the pop occurs only after both sinks accept.
- Hold lcd_rdy=0 with uart_rdy=1 and push 17 bytes (DEPTH=16) → in_rdy drops after 16 pushes, the 17th waits, and level=16. Releasing lcd_rdy drains all 17 bytes in order.
- STALL_TIMEOUT=8, lcd_rdy=0 permanently, push 3 bytes → uart receives all 3; drop_cnt=3; each head pops 8 cycles after lcd_val rose.
- Assert rstin low mid-stream with level=5 → level=0, both val=0, drop_cnt=0 immediately, without waiting for a clock edge; the next pushed byte is the first delivered.
